multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the processor datapath. It replaces the single-cycle control decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back over several clocks. It drives the mux selects, register-file, IR and PC enables, and memory strobes. It handshakes with a variable-latency memory and counts retired instructions.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register (valid from DECODE on)
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond  out  1  unconditional / zero-qualified PC enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1  memory strobes
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- halted  out  1  set on an illegal opcode; cleared only by rst
- instr_count  out  COUNT_W  retired-instruction count, wraps modulo 2^COUNT_W

## Operation
- Outputs are decoded from the state. Exception: ir_write, FETCH pc_write and MEM_WR instr_done are additionally ANDed with mem_ready. Any control not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC_R
  - 0x23 or 0x2B → MEM_ADDR
  - 0x08 → ADDI_EX
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - any other value → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready; instr_done = mem_ready; then → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, instr_done=1. Next: FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- TRAP: halted=1, all other outputs 0. Absorbing until rst. A trapped instruction does not assert instr_done.
- instr_count increments at the clock edge where instr_done=1. It wraps from all-ones to 0 with no flag.

## Timing
- rst sampled high: state becomes IDLE and instr_count becomes 0 at that edge. All outputs are 0 from the next cycle and through the IDLE cycle.
- rst wins over every transition, including mid-MEM_RD/MEM_WR. Strobes drop the cycle after rst is sampled. No write completes after that edge.
- First FETCH is the second cycle after rst deasserts.
- Cycles per instruction, zero-wait memory (mem_ready=1), FETCH through last state:
  - beq, j: 3
  - R-type, addi, sw: 4
  - lw: 5
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in states that do not assert mem_read or mem_write.
- instr_count shows the new value in the cycle after the instr_done pulse.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state enum: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, ALU_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP, TRAP
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_op, alu_src_b and pc_source encodings
- Single module. The next-state logic, output decode and counter are small enough that no sub-module is warranted.

## Test plan
- Reset, then R-type (opcode 0x00), mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB. In ALU_WB: reg_write=1, reg_dst=1, instr_done=1. instr_count = 1.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD -> mem_read=1 and iord=1 held for 3 cycles. MEM_WB shows mem_to_reg=1. Total 7 cycles.
- beq (0x04) -> third cycle shows pc_write_cond=1, pc_source=01, alu_op=01. Then FETCH.
- Opcode 0x3F -> TRAP with halted=1. Every other output stays 0 for 20 cycles, instr_count unchanged. rst clears halted.
- sw (0x2B) with rst asserted on the second MEM_WR wait cycle -> mem_write=0 the next cycle, state IDLE, instr_count=0.
- COUNT_W=4, 17 back-to-back j (0x02) instructions -> instr_count reads 15, then 0, then 1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencing controller: state encoding,
// opcode values and datapath select encodings.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WB   = 4'd5,
      MEM_WR   = 4'd6,
      EXEC_R   = 4'd7,
      ALU_WB   = 4'd8,
      ADDI_EX  = 4'd9,
      ADDI_WB  = 4'd10,
      BRANCH   = 4'd11,
      JUMP     = 4'd12,
      TRAP     = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // Unrecognised opcodes land in TRAP, which is absorbing until reset.
   function automatic state_e decode_next(input logic [5:0] op);
      state_e s;
      case (op)
         OP_RTYPE:     s = EXEC_R;
         OP_LW, OP_SW: s = MEM_ADDR;
         OP_ADDI:      s = ADDI_EX;
         OP_BEQ:       s = BRANCH;
         OP_J:         s = JUMP;
         default:      s = TRAP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction opcode, memory handshake
// and every datapath control the sequencer drives.
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer stepping each instruction through fetch/decode/execute/memory/
// write-back, with a variable-latency memory handshake and a retired counter.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   multicycle_ctrl_if.master  bus,
   output logic               instr_done,
   output logic               halted,
   output logic [COUNT_W-1:0] instr_count
);

   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_e             r_state;
   state_e             w_next_state;
   logic [COUNT_W-1:0] r_count;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and state-decoded controls; mem_ready only qualifies the memory states.
   always_comb begin
      w_next_state      = r_state;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = SRCB_REG;
      bus.alu_op        = ALU_ADD;
      bus.pc_source     = PC_SRC_ALU;
      instr_done        = 1'b0;
      halted            = 1'b0;
      case (r_state)
         IDLE: begin
            w_next_state = FETCH;
         end
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
            if (bus.mem_ready) begin
               w_next_state = DECODE;
            end else begin
               w_next_state = FETCH;
            end
         end
         DECODE: begin
            bus.alu_src_b = SRCB_IMM_SH2;
            w_next_state  = decode_next(bus.opcode);
         end
         MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            if (bus.opcode == OP_SW) begin
               w_next_state = MEM_WR;
            end else begin
               w_next_state = MEM_RD;
            end
         end
         MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready) begin
               w_next_state = MEM_WB;
            end else begin
               w_next_state = MEM_RD;
            end
         end
         MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            instr_done     = 1'b1;
            w_next_state   = FETCH;
         end
         MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
            instr_done    = bus.mem_ready;
            if (bus.mem_ready) begin
               w_next_state = FETCH;
            end else begin
               w_next_state = MEM_WR;
            end
         end
         EXEC_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_FUNCT;
            w_next_state  = ALU_WB;
         end
         ALU_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            instr_done    = 1'b1;
            w_next_state  = FETCH;
         end
         ADDI_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            w_next_state  = ADDI_WB;
         end
         ADDI_WB: begin
            bus.reg_write = 1'b1;
            instr_done    = 1'b1;
            w_next_state  = FETCH;
         end
         BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALU_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = PC_SRC_ALUOUT;
            instr_done        = 1'b1;
            w_next_state      = FETCH;
         end
         JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_SRC_JUMP;
            instr_done    = 1'b1;
            w_next_state  = FETCH;
         end
         TRAP: begin
            halted       = 1'b1;
            w_next_state = TRAP;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (instr_done) begin
         r_count <= r_count + CNT_ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each driven cycle queues its expected controls and count;
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

   typedef enum int {
      T_IDLE, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR,
      T_EXEC_R, T_ALU_WB, T_ADDI_EX, T_ADDI_WB, T_BRANCH, T_JUMP, T_TRAP
   } st_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       halted;
   } ctrl_t;

   logic       clk;
   logic       rst;
   logic       instr_done;
   logic       halted;
   logic [3:0] instr_count;

   multicycle_ctrl_if bus_if ();

   multicycle_ctrl #(.COUNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if),
      .instr_done  (instr_done),
      .halted      (halted),
      .instr_count (instr_count)
   );

   ctrl_t      ctrl_q[$];
   logic [3:0] cnt_q[$];
   string      tag_q[$];
   logic [3:0] exp_cnt;
   int         n_tests;
   int         n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hand-written expected controls for each state.
   function automatic ctrl_t exp_ctrl(input st_t st, input logic mr);
      ctrl_t c;
      c = '0;
      case (st)
         T_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
         T_DECODE:   begin c.alu_src_b = 2'b11; end
         T_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         T_MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
         T_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
         T_MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = mr; end
         T_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         T_ALU_WB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
         T_ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         T_ADDI_WB:  begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
         T_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                           c.pc_source = 2'b01; c.instr_done = 1'b1; end
         T_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
         T_TRAP:     begin c.halted = 1'b1; end
         default:    begin c = '0; end
      endcase
      return c;
   endfunction

   task automatic step(input st_t st, input logic mr, input logic [5:0] op, input logic r,
                       input string tag);
      ctrl_t c;
      rst              = r;
      bus_if.mem_ready = mr;
      bus_if.opcode    = op;
      c = exp_ctrl(st, mr);
      ctrl_q.push_back(c);
      cnt_q.push_back(exp_cnt);
      tag_q.push_back(tag);
      if (r) exp_cnt = 4'd0;
      else if (c.instr_done) exp_cnt = exp_cnt + 4'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_jump(input string tag);
      step(T_FETCH,  1'b1, 6'h02, 1'b0, tag);
      step(T_DECODE, 1'b1, 6'h02, 1'b0, tag);
      step(T_JUMP,   1'b1, 6'h02, 1'b0, tag);
   endtask

   // Monitor: compares every queued cycle away from the active edge.
   initial begin
      ctrl_t      act;
      ctrl_t      e;
      logic [3:0] ec;
      string      t;
      forever begin
         @(negedge clk);
         if (ctrl_q.size() > 0) begin
            e  = ctrl_q.pop_front();
            ec = cnt_q.pop_front();
            t  = tag_q.pop_front();
            act = '{bus_if.pc_write, bus_if.pc_write_cond, bus_if.iord, bus_if.mem_read,
                    bus_if.mem_write, bus_if.ir_write, bus_if.reg_dst, bus_if.mem_to_reg,
                    bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                    bus_if.pc_source, instr_done, halted};
            n_tests++;
            if (act !== e || instr_count !== ec) begin
               n_fail++;
               $display("FAIL %s: got ctrl=%05h count=%0d, expected ctrl=%05h count=%0d",
                        t, act, instr_count, e, ec);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_cnt = 4'd0;
      rst = 1'b1;
      bus_if.mem_ready = 1'b0;
      bus_if.opcode    = 6'h00;
      repeat (2) @(posedge clk);
      #1;

      step(T_IDLE, 1'b1, 6'h00, 1'b1, "reset_hold");
      step(T_IDLE, 1'b1, 6'h00, 1'b0, "reset_idle");

      step(T_FETCH,  1'b1, 6'h00, 1'b0, "r_fetch");
      step(T_DECODE, 1'b1, 6'h00, 1'b0, "r_decode");
      step(T_EXEC_R, 1'b1, 6'h00, 1'b0, "r_exec");
      step(T_ALU_WB, 1'b1, 6'h00, 1'b0, "r_wb");

      step(T_FETCH,    1'b1, 6'h23, 1'b0, "lw_fetch");
      step(T_DECODE,   1'b0, 6'h23, 1'b0, "lw_decode");
      step(T_MEM_ADDR, 1'b1, 6'h23, 1'b0, "lw_addr");
      step(T_MEM_RD,   1'b0, 6'h23, 1'b0, "lw_rd_wait1");
      step(T_MEM_RD,   1'b0, 6'h23, 1'b0, "lw_rd_wait2");
      step(T_MEM_RD,   1'b1, 6'h23, 1'b0, "lw_rd_ready");
      step(T_MEM_WB,   1'b0, 6'h23, 1'b0, "lw_wb");

      step(T_FETCH,  1'b1, 6'h04, 1'b0, "beq_fetch");
      step(T_DECODE, 1'b1, 6'h04, 1'b0, "beq_decode");
      step(T_BRANCH, 1'b1, 6'h04, 1'b0, "beq_branch");

      step(T_FETCH,   1'b0, 6'h08, 1'b0, "addi_fetch_wait");
      step(T_FETCH,   1'b1, 6'h08, 1'b0, "addi_fetch");
      step(T_DECODE,  1'b1, 6'h08, 1'b0, "addi_decode");
      step(T_ADDI_EX, 1'b0, 6'h08, 1'b0, "addi_ex");
      step(T_ADDI_WB, 1'b1, 6'h08, 1'b0, "addi_wb");

      do_jump("j_single");

      step(T_FETCH,    1'b1, 6'h2B, 1'b0, "sw_fetch");
      step(T_DECODE,   1'b1, 6'h2B, 1'b0, "sw_decode");
      step(T_MEM_ADDR, 1'b1, 6'h2B, 1'b0, "sw_addr");
      step(T_MEM_WR,   1'b1, 6'h2B, 1'b0, "sw_wr");

      step(T_FETCH,    1'b1, 6'h2B, 1'b0, "swrst_fetch");
      step(T_DECODE,   1'b1, 6'h2B, 1'b0, "swrst_decode");
      step(T_MEM_ADDR, 1'b1, 6'h2B, 1'b0, "swrst_addr");
      step(T_MEM_WR,   1'b0, 6'h2B, 1'b0, "swrst_wait1");
      step(T_MEM_WR,   1'b0, 6'h2B, 1'b1, "swrst_wait2_rst");
      step(T_IDLE,     1'b1, 6'h2B, 1'b0, "swrst_idle");

      do_jump("pre_trap_j");
      step(T_FETCH,  1'b1, 6'h3F, 1'b0, "trap_fetch");
      step(T_DECODE, 1'b1, 6'h3F, 1'b0, "trap_decode");
      for (int i = 0; i < 20; i++) begin
         logic [5:0] op_v;
         op_v = 6'(i * 5);
         step(T_TRAP, i[0], op_v, 1'b0, "trap_hold");
      end
      step(T_TRAP, 1'b1, 6'h02, 1'b1, "trap_rst");
      step(T_IDLE, 1'b1, 6'h02, 1'b0, "trap_cleared");

      for (int k = 0; k < 17; k++) begin
         do_jump("wrap_j");
      end
      step(T_FETCH, 1'b0, 6'h02, 1'b0, "wrap_final");

      repeat (2) @(posedge clk);
      n_tests++;
      if (ctrl_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", ctrl_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
